// File: rtl/mul_add_unit.sv
// mul_add_unit: iterative shift-add multiply-accumulate, c = q*b + r.
// A 2N-bit accumulator is seeded with r. Over N RUN cycles, mcand = b << i
// is added whenever bit i of q is set. Status flags follow the ALU style.
// Optional build macro MUL_ADD_EARLY_EXIT_EN ends RUN as soon as the
// remaining multiplier bits are all zero.
module mul_add_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] q,
  input  logic [N-1:0] b,
  input  logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         cout,
  output logic         zero,
  output logic         overflow
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_c;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;

  logic [2*N-1:0]   w_acc_nxt;
  logic [N-1:0]     w_mplier_nxt;
  logic             w_last;

  // One shift-add step. The accumulator cannot wrap because the largest
  // possible result, (2^N-1)^2 + 2^N-1, still fits in 2N bits.
  assign w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_nxt = r_mplier >> 1;

`ifdef MUL_ADD_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain. A q of 0 still runs one cycle.
  assign w_last = (r_cnt == LAST) || (w_mplier_nxt == '0);
`else
  // Fixed latency: always run all N iterations.
  assign w_last = (r_cnt == LAST);
`endif

  // Control FSM and datapath. The result flags are loaded only in DONE, so
  // they hold their values through later RUN phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= {{N{1'b0}}, r};
            r_mcand  <= {{N{1'b0}}, b};
            r_mplier <= q;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_c     <= r_acc[N-1:0];
          r_cout  <= r_acc[N];
          r_zero  <= (r_acc == '0);
          r_ovf   <= |r_acc[2*N-1:N+1];
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign c        = r_c;
  assign cout     = r_cout;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule

// File: doc/mul_add_unit.md
# mul_add_unit

Iterative shift-add multiply-accumulate unit computing c = q·b + r, the inverse of the remainder operation in the integer ALU path. The modulo unit produces a remainder from a dividend and a divisor; this block reconstructs the dividend from a quotient, divisor and remainder, and is also used as a general unsigned MAC. It sits beside the ALU as a multi-cycle functional unit with a start/done handshake. Its status flags mirror the ALU conventions: c, cout, zero and overflow.

## Interface
- N, default 32: operand and result width in bits; N ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- q  input  N  multiplier (quotient); unsigned.
- b  input  N  multiplicand (divisor); unsigned.
- r  input  N  addend (remainder); unsigned.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- c  output  N  low N bits of q·b + r.
- cout  output  1  bit N of the full result.
- zero  output  1  full 2N-bit result equals 0.
- overflow  output  1  OR of result bits 2N-1..N+1.

## Operation
- Internal accumulator is 2N bits wide. The maximum value (2^N−1)² + 2^N−1 < 2^2N, so the accumulator never wraps.
- States are IDLE, RUN and DONE.
- IDLE:
  - On start=1, capture operands: acc ← zero-extended r, mcand ← zero-extended b (2N bits), mplier ← q, cnt ← 0.
  - Go to RUN.
- RUN, each cycle:
  - If mplier[0], acc ← acc + mcand.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
  - Leave for DONE after the iteration with cnt = N−1.
- DONE, one cycle:
  - Outputs are updated from the final acc; done=1.
  - Next state is IDLE.
- c, cout, zero and overflow are registered. They hold their value from DONE until the next DONE; they do not change during RUN.
- start is ignored in RUN and DONE; there is no queueing. Operand inputs are don't-care except at the accepting edge.
- Reset mid-operation: state → IDLE immediately, the operation is aborted and no done is produced.

## Timing
- Reset values: busy=0, done=0, c=0, cout=0, zero=0, overflow=0; internal registers are cleared.
- Let start be sampled at edge E0. busy is high from E0 through edge EN, which is the N RUN cycles.
- done and the valid outputs appear after E(N+1) and remain for one cycle. Fixed latency is N+1 cycles from start to done.
- The earliest next accepted start is at the edge that ends the DONE cycle. start held high continuously therefore issues one operation every N+2 cycles.
- busy and done are never high simultaneously.

## Configuration
- MUL_ADD_EARLY_EXIT_EN:
  - When defined, RUN exits to DONE after any iteration whose updated mplier equals 0.
  - RUN length becomes max(1, index of the highest set bit of q + 1) cycles.
  - q=0 still takes 1 RUN cycle.
  - Results are identical to the fixed-latency version.
- When undefined, RUN always lasts exactly N cycles, giving deterministic latency N+1.

## Test plan
- N=32, q=7, b=6, r=5 → c=47, cout=0, zero=0, overflow=0; done exactly 33 cycles after the start edge (macro off).
- q=0xFFFFFFFF, b=2, r=0 → result 0x1_FFFFFFFE: c=0xFFFFFFFE, cout=1, overflow=0, zero=0.
- q=0x20000, b=0x10000, r=0 → result 2^33: c=0, cout=0, overflow=1, zero=0. Then q=0x10000, b=0x10000 → c=0, cout=1, overflow=0.
- q=0, b=5, r=0 → zero=1, c=0.
- Macro on: q=0, b=9, r=3 → c=3 with done 2 cycles after start. Then q=0xFFFFFFFF, b=1, r=1 → c=0, cout=1 at 33 cycles.
- Reset and handshake:
  - Start q=3, b=3, r=0, assert rst during RUN cycle 10 → all outputs 0, no done pulse.
  - A start pulse during RUN is ignored.
  - A subsequent clean start → c=9.
